aidc_lite_comp_zrle: RTL and testbench

- Zero-run-length (ZRLE) compressor for one AIDC-Lite block.
- Accepts eight 64-bit words; each word is four 16-bit symbols, sym3 = data[63:48] down to sym0 = data[15:0].
- Encodes each word into a prefix code plus its nonzero symbols and packs the bit stream MSB-first.
- Emits the stream as 32-bit words with sop/eop, in the exact format consumed by the ZRLE decompressor. The first word carries a 2-bit algorithm prefix in bits [31:30].

---
 rtl/aidc_lite_zrle_pkg.sv | 67 ++++++
 rtl/aidc_lite_zrle_enc.sv | 41 ++++
 rtl/aidc_lite_comp_zrle.sv | 215 +++++++++++++++++++++
 tb/tb_aidc_lite_comp_zrle.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aidc_lite_zrle_pkg.sv
// ---------------------------------------------------------------------------
// aidc_lite_zrle_pkg
// Shared definitions for the AIDC-Lite zero-run-length (ZRLE) compressor:
// the algorithm prefix, stream size limits, the per-word pattern code table
// and the controller state encoding.
// Optional feature macro used by the top: AIDC_LITE_ZRLE_BYPASS_EN.
// ---------------------------------------------------------------------------
package aidc_lite_zrle_pkg;

    // Algorithm ID carried in bits [31:30] of the first output word
    localparam logic [1:0] PREFIX_ZRLE = 2'b01;

    // Worst-case stream: 2 prefix bits + 8 words x 66 bits
    localparam int ZRLE_MAX_BITS  = 530;
    localparam int ZRLE_CODE_BITS = 66;
    localparam int ZRLE_BLK_WORDS = 8;

    // Pattern code lengths (code only, symbols excluded)
    localparam logic [2:0] PAT_LEN_ZERO = 3'd6;  // ZZZZ / ZZZN
    localparam logic [2:0] PAT_LEN_ONE  = 3'd5;  // one nonzero symbol in sym3..sym1
    localparam logic [2:0] PAT_LEN_TWO  = 3'd4;  // two or three nonzero symbols
    localparam logic [2:0] PAT_LEN_ALL  = 3'd2;  // NNNN

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } zrle_state_e;

    // Pattern code, right-aligned; nz = {sym3!=0, sym2!=0, sym1!=0, sym0!=0}
    function automatic logic [5:0] pattern_code(input logic [3:0] nz);
        logic [5:0] c;
        case (nz)
            4'b0000: c = 6'b000000;
            4'b0001: c = 6'b000001;
            4'b0010: c = 6'b000001;  // 00001
            4'b0100: c = 6'b000010;  // 00010
            4'b1000: c = 6'b000011;  // 00011
            4'b0011: c = 6'b000010;  // 0010
            4'b0101: c = 6'b000011;  // 0011
            4'b1001: c = 6'b000100;  // 0100
            4'b0110: c = 6'b000101;  // 0101
            4'b1010: c = 6'b000110;  // 0110
            4'b1100: c = 6'b000111;  // 0111
            4'b0111: c = 6'b001000;  // 1000
            4'b1011: c = 6'b001001;  // 1001
            4'b1101: c = 6'b001010;  // 1010
            4'b1110: c = 6'b001011;  // 1011
            4'b1111: c = 6'b000011;  // 11
            default: c = 6'b000000;
        endcase
        return c;
    endfunction

    // Pattern code length matching pattern_code()
    function automatic logic [2:0] pattern_len(input logic [3:0] nz);
        logic [2:0] l;
        case (nz)
            4'b0000, 4'b0001:                   l = PAT_LEN_ZERO;
            4'b0010, 4'b0100, 4'b1000:          l = PAT_LEN_ONE;
            4'b1111:                            l = PAT_LEN_ALL;
            default:                            l = PAT_LEN_TWO;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/aidc_lite_zrle_enc.sv
// ---------------------------------------------------------------------------
// aidc_lite_zrle_enc
// Combinational per-word encoder: pattern code followed by the nonzero
// symbols (sym3 first), left-aligned in a 66-bit field.
// Ports:
//   data  in  64  four 16-bit symbols, sym3 = data[63:48]
//   code  out 66  encoded bits, MSB-first, left-aligned, tail zero
//   len   out 7   number of valid bits in code (6..66)
// ---------------------------------------------------------------------------
module aidc_lite_zrle_enc
    import aidc_lite_zrle_pkg::*;
(
    input  logic [63:0] data,
    output logic [65:0] code,
    output logic [6:0]  len
);

    logic [3:0]  nz_s;
    logic [65:0] acc_s;
    logic [6:0]  len_s;

    assign nz_s = {|data[63:48], |data[47:32], |data[31:16], |data[15:0]};

    // Build the code right-aligned, appending symbols, then left-align it
    always_comb begin
        acc_s = 66'(pattern_code(nz_s));
        len_s = {4'b0000, pattern_len(nz_s)};
        for (int i = 3; i >= 0; i--) begin
            if (nz_s[i]) begin
                acc_s = {acc_s[49:0], data[i*16 +: 16]};
                len_s = len_s + 7'd16;
            end else begin
                acc_s = acc_s;
                len_s = len_s;
            end
        end
        code = acc_s << (7'd66 - len_s);
        len  = len_s;
    end

endmodule

// File: rtl/aidc_lite_comp_zrle.sv
// ---------------------------------------------------------------------------
// aidc_lite_comp_zrle
// ZRLE compressor for one AIDC-Lite block of up to eight 64-bit words.
// Packs {PREFIX, code0, code1, ...} MSB-first into a 530-bit buffer and
// drains it as 32-bit words (sop on first, eop on last).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   valid_i/sop_i/eop_i/data_i input word stream (accepted on valid_i&ready_o)
//   ready_o                    low while draining
//   valid_o/sop_o/eop_o        output framing, no backpressure
//   data_o [31:0]              compressed word, zero when valid_o is low
//   len_o  [9:0]               total stream bits, zero when valid_o is low
//   bypass_o                   (AIDC_LITE_ZRLE_BYPASS_EN only) one-cycle
//                              pulse instead of a stream when L > 512
// ---------------------------------------------------------------------------
module aidc_lite_comp_zrle
    import aidc_lite_zrle_pkg::*;
#(
    parameter logic [1:0] PREFIX   = PREFIX_ZRLE,
    parameter int         BUF_SIZE = ZRLE_MAX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        sop_i,
    input  logic        eop_i,
    input  logic [63:0] data_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic        sop_o,
    output logic        eop_o,
    output logic [31:0] data_o,
    output logic [9:0]  len_o
`ifdef AIDC_LITE_ZRLE_BYPASS_EN
    ,
    output logic        bypass_o
`endif
);

    zrle_state_e         state_r, state_n_s;
    logic [BUF_SIZE-1:0] buf_r, buf_n_s;
    logic [9:0]          len_r, len_n_s;
    logic [3:0]          wcnt_r, wcnt_n_s;
    logic [4:0]          dcnt_r, dcnt_n_s;

    logic                ready_r;
    logic                valid_r, valid_n_s;
    logic                sop_r, sop_n_s;
    logic                eop_r, eop_n_s;
    logic [31:0]         data_r, data_n_s;
    logic [9:0]          olen_r, olen_n_s;

    logic [65:0]         code_s;
    logic [6:0]          clen_s;
    logic                accept_s;
    logic                last_s;
    logic                bypass_hit_s;
    logic [BUF_SIZE-1:0] first_buf_s;
    logic [BUF_SIZE-1:0] app_buf_s;

    aidc_lite_zrle_enc u_enc (
        .data (data_i),
        .code (code_s),
        .len  (clen_s)
    );

    assign accept_s    = valid_i & ready_r;
    assign first_buf_s = BUF_SIZE'({PREFIX, code_s}) << (BUF_SIZE - ZRLE_CODE_BITS - 2);
    assign app_buf_s   = (BUF_SIZE'(code_s) << (BUF_SIZE - ZRLE_CODE_BITS)) >> len_r;
    // Current drain word is the last once (dcnt+1)*32 covers all L bits
    assign last_s      = ({dcnt_r + 5'd1, 5'd0} >= len_r);

`ifdef AIDC_LITE_ZRLE_BYPASS_EN
    // No gain over raw 512 bits: skip the stream entirely
    assign bypass_hit_s = (dcnt_r == 5'd0) && (len_r > 10'd512);
`else
    assign bypass_hit_s = 1'b0;
`endif

    // Next-state, buffer packing and output word selection
    always_comb begin
        state_n_s = state_r;
        buf_n_s   = buf_r;
        len_n_s   = len_r;
        wcnt_n_s  = wcnt_r;
        dcnt_n_s  = dcnt_r;
        valid_n_s = 1'b0;
        sop_n_s   = 1'b0;
        eop_n_s   = 1'b0;
        data_n_s  = 32'd0;
        olen_n_s  = 10'd0;
        case (state_r)
            IDLE: begin
                if (accept_s && sop_i) begin
                    buf_n_s   = first_buf_s;
                    len_n_s   = 10'd2 + {3'b000, clen_s};
                    wcnt_n_s  = 4'd1;
                    dcnt_n_s  = 5'd0;
                    state_n_s = eop_i ? DRAIN : COLLECT;
                end else begin
                    state_n_s = IDLE;
                end
            end
            COLLECT: begin
                if (accept_s) begin
                    if (sop_i) begin
                        // Restart: prior words of the block are discarded
                        buf_n_s   = first_buf_s;
                        len_n_s   = 10'd2 + {3'b000, clen_s};
                        wcnt_n_s  = 4'd1;
                        dcnt_n_s  = 5'd0;
                        state_n_s = eop_i ? DRAIN : COLLECT;
                    end else if (wcnt_r == 4'(ZRLE_BLK_WORDS)) begin
                        // Overlong block: drop the extra word and drain
                        dcnt_n_s  = 5'd0;
                        state_n_s = DRAIN;
                    end else begin
                        buf_n_s   = buf_r | app_buf_s;
                        len_n_s   = len_r + {3'b000, clen_s};
                        wcnt_n_s  = wcnt_r + 4'd1;
                        dcnt_n_s  = 5'd0;
                        state_n_s = eop_i ? DRAIN : COLLECT;
                    end
                end else begin
                    state_n_s = COLLECT;
                end
            end
            DRAIN: begin
                if (bypass_hit_s) begin
                    buf_n_s   = '0;
                    len_n_s   = 10'd0;
                    wcnt_n_s  = 4'd0;
                    dcnt_n_s  = 5'd0;
                    state_n_s = IDLE;
                end else begin
                    valid_n_s = 1'b1;
                    sop_n_s   = (dcnt_r == 5'd0);
                    data_n_s  = buf_r[BUF_SIZE-1 -: 32];
                    olen_n_s  = len_r;
                    buf_n_s   = buf_r << 32;
                    dcnt_n_s  = dcnt_r + 5'd1;
                    if (last_s) begin
                        eop_n_s   = 1'b1;
                        buf_n_s   = '0;
                        len_n_s   = 10'd0;
                        wcnt_n_s  = 4'd0;
                        dcnt_n_s  = 5'd0;
                        state_n_s = IDLE;
                    end else begin
                        state_n_s = DRAIN;
                    end
                end
            end
            default: begin
                buf_n_s   = '0;
                len_n_s   = 10'd0;
                wcnt_n_s  = 4'd0;
                dcnt_n_s  = 5'd0;
                state_n_s = IDLE;
            end
        endcase
    end

    // State, buffer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            buf_r   <= '0;
            len_r   <= 10'd0;
            wcnt_r  <= 4'd0;
            dcnt_r  <= 5'd0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            sop_r   <= 1'b0;
            eop_r   <= 1'b0;
            data_r  <= 32'd0;
            olen_r  <= 10'd0;
        end else begin
            state_r <= state_n_s;
            buf_r   <= buf_n_s;
            len_r   <= len_n_s;
            wcnt_r  <= wcnt_n_s;
            dcnt_r  <= dcnt_n_s;
            ready_r <= (state_n_s != DRAIN);
            valid_r <= valid_n_s;
            sop_r   <= sop_n_s;
            eop_r   <= eop_n_s;
            data_r  <= data_n_s;
            olen_r  <= olen_n_s;
        end
    end

`ifdef AIDC_LITE_ZRLE_BYPASS_EN
    logic bypass_r;

    // One-cycle bypass pulse in place of the stream
    always_ff @(posedge clk) begin
        if (rst) begin
            bypass_r <= 1'b0;
        end else begin
            bypass_r <= (state_r == DRAIN) && bypass_hit_s;
        end
    end

    assign bypass_o = bypass_r;
`endif

    assign ready_o = ready_r;
    assign valid_o = valid_r;
    assign sop_o   = sop_r;
    assign eop_o   = eop_r;
    assign data_o  = data_r;
    assign len_o   = olen_r;

endmodule

// File: tb/tb_aidc_lite_comp_zrle.sv
// ---------------------------------------------------------------------------
// tb_aidc_lite_comp_zrle
// Directed bench for the ZRLE compressor; expected stream words are
// hand-derived from the code table.
// ---------------------------------------------------------------------------
module tb_aidc_lite_comp_zrle;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        sop_i;
    logic        eop_i;
    logic [63:0] data_i;
    logic        ready_o;
    logic        valid_o;
    logic        sop_o;
    logic        eop_o;
    logic [31:0] data_o;
    logic [9:0]  len_o;
`ifdef AIDC_LITE_ZRLE_BYPASS_EN
    logic        bypass_o;
`endif

    aidc_lite_comp_zrle dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .sop_i   (sop_i),
        .eop_i   (eop_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .sop_o   (sop_o),
        .eop_o   (eop_o),
        .data_o  (data_o),
        .len_o   (len_o)
`ifdef AIDC_LITE_ZRLE_BYPASS_EN
        ,
        .bypass_o(bypass_o)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ow [0:31];
    logic        oeop [0:31];
    int          ocnt;
    int          sop_cnt;
    int          eop_cnt;
    int          ready_low;
    int          idle_dirty;
    logic [9:0]  olen;
    logic        byp_seen;

    localparam logic [63:0] W_ALLN = 64'h1111_2222_3333_4444;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic s, input logic e, input logic [63:0] d);
        @(negedge clk);
        valid_i = 1'b1;
        sop_i   = s;
        eop_i   = e;
        data_i  = d;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        sop_i   = 1'b0;
        eop_i   = 1'b0;
        data_i  = 64'd0;
    endtask

    // Record output words until eop, a bypass pulse, max_words, or timeout
    task automatic collect(input int max_words);
        ocnt = 0; sop_cnt = 0; eop_cnt = 0; ready_low = 0;
        idle_dirty = 0; olen = 10'd0; byp_seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!ready_o) ready_low++;
`ifdef AIDC_LITE_ZRLE_BYPASS_EN
            if (bypass_o) byp_seen = 1'b1;
`endif
            if (valid_o) begin
                if (ocnt < 32) begin
                    ow[ocnt]   = data_o;
                    oeop[ocnt] = eop_o;
                end
                olen = len_o;
                if (sop_o) sop_cnt++;
                if (eop_o) eop_cnt++;
                ocnt++;
            end else if (data_o != 32'd0 || len_o != 10'd0) begin
                idle_dirty++;
            end
            if ((valid_o && eop_o) || byp_seen || ocnt >= max_words) break;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, {63'd0, valid_o}, 64'd0);
        chk({tag, "_data"},  {32'd0, data_o},  64'd0);
        chk({tag, "_sop"},   {63'd0, sop_o},   64'd0);
        chk({tag, "_eop"},   {63'd0, eop_o},   64'd0);
        chk({tag, "_len"},   {54'd0, len_o},   64'd0);
        chk({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = 64'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // 1: eight zero words -> L=50, two words
        send(1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 6; i++) send(1'b0, 1'b0, 64'd0);
        send(1'b0, 1'b1, 64'd0);
        collect(32);
        chk("zero_cnt", 64'(ocnt), 64'd2);
        chk("zero_w0", {32'd0, ow[0]}, 64'h4000_0000);
        chk("zero_w1", {32'd0, ow[1]}, 64'h0000_0000);
        chk("zero_len", {54'd0, olen}, 64'd50);
        chk("zero_ready_low", 64'(ready_low), 64'd2);
        chk("zero_sops", 64'(sop_cnt), 64'd1);
        chk("zero_eop_last", {63'd0, oeop[1]}, 64'd1);
        chk("zero_idle_clean", 64'(idle_dirty), 64'd0);

        // 2: single nonzero sym0, with input gaps -> L=66
        send(1'b1, 1'b0, 64'h0000_0000_0000_ABCD);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) send(1'b0, 1'b0, 64'd0);
        repeat (3) @(negedge clk);
        send(1'b0, 1'b1, 64'd0);
        collect(32);
        chk("abcd_cnt", 64'(ocnt), 64'd3);
        chk("abcd_w0", {32'd0, ow[0]}, 64'h41AB_CD00);
        chk("abcd_w2", {32'd0, ow[2]}, 64'h0000_0000);
        chk("abcd_len", {54'd0, olen}, 64'd66);

        // 3: two nonzero symbols (ZZNN) -> L=80
        send(1'b1, 1'b0, 64'h0000_0000_1234_5678);
        for (int i = 0; i < 6; i++) send(1'b0, 1'b0, 64'd0);
        send(1'b0, 1'b1, 64'd0);
        collect(32);
        chk("zznn_cnt", 64'(ocnt), 64'd3);
        chk("zznn_w0", {32'd0, ow[0]}, 64'h4848_D159);
        chk("zznn_w1", {32'd0, ow[1]}, 64'hE000_0000);
        chk("zznn_len", {54'd0, olen}, 64'd80);

        // 4: worst case, all symbols nonzero -> L=530, 17 words
        send(1'b1, 1'b0, W_ALLN);
        for (int i = 0; i < 6; i++) send(1'b0, 1'b0, W_ALLN);
        send(1'b0, 1'b1, W_ALLN);
        collect(32);
`ifdef AIDC_LITE_ZRLE_BYPASS_EN
        chk("max_byp_cnt", 64'(ocnt), 64'd0);
        chk("max_byp_pulse", {63'd0, byp_seen}, 64'd1);
`else
        chk("max_cnt", 64'(ocnt), 64'd17);
        chk("max_w0", {32'd0, ow[0]}, 64'h7111_1222);
        chk("max_w1", {32'd0, ow[1]}, 64'h2333_3444);
        chk("max_w16", {32'd0, ow[16]}, 64'hD111_0000);
        chk("max_len", {54'd0, olen}, 64'd530);
        chk("max_eops", 64'(eop_cnt), 64'd1);
        chk("max_eop_last", {63'd0, oeop[16]}, 64'd1);
`endif
        repeat (2) @(negedge clk);

        // 5: ninth word without eop is dropped and forces drain
        send(1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 7; i++) send(1'b0, 1'b0, 64'd0);
        send(1'b0, 1'b0, 64'h0000_0000_0000_ABCD);
        collect(32);
        chk("ovf_cnt", 64'(ocnt), 64'd2);
        chk("ovf_w0", {32'd0, ow[0]}, 64'h4000_0000);
        chk("ovf_w1", {32'd0, ow[1]}, 64'h0000_0000);
        chk("ovf_len", {54'd0, olen}, 64'd50);

        // 6: back-to-back blocks, valid_i held high through the drain
        send(1'b1, 1'b0, 64'h0000_0000_1234_5678);
        @(negedge clk);
        valid_i = 1'b1; sop_i = 1'b0; eop_i = 1'b1; data_i = 64'd0;
        @(posedge clk);
        #1;
        sop_i = 1'b1; eop_i = 1'b1; data_i = 64'hFFFF_0000_0000_0000;
        collect(32);
        chk("b2b_a_cnt", 64'(ocnt), 64'd2);
        chk("b2b_a_w0", {32'd0, ow[0]}, 64'h4848_D159);
        chk("b2b_a_w1", {32'd0, ow[1]}, 64'hE000_0000);
        chk("b2b_a_len", {54'd0, olen}, 64'd44);
        @(posedge clk);
        #1;
        valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = 64'd0;
        collect(32);
        chk("b2b_b_cnt", 64'(ocnt), 64'd1);
        chk("b2b_b_w0", {32'd0, ow[0]}, 64'h47FF_FE00);
        chk("b2b_b_len", {54'd0, olen}, 64'd23);
        chk("b2b_b_sops", 64'(sop_cnt), 64'd1);

        // 7: reset during drain word 5, then a clean block
        for (int i = 0; i < 7; i++) send(i == 0, 1'b0, W_ALLN);
        send(1'b0, 1'b1, 64'd0);
        collect(5);
        chk("rst_pre_cnt", 64'(ocnt), 64'd5);
        chk("rst_pre_w0", {32'd0, ow[0]}, 64'h7111_1222);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        collect(32);
        chk("rst_no_tail", 64'(ocnt), 64'd0);
        send(1'b1, 1'b0, 64'h0000_0000_0000_ABCD);
        for (int i = 0; i < 6; i++) send(1'b0, 1'b0, 64'd0);
        send(1'b0, 1'b1, 64'd0);
        collect(32);
        chk("rst_post_cnt", 64'(ocnt), 64'd3);
        chk("rst_post_w0", {32'd0, ow[0]}, 64'h41AB_CD00);
        chk("rst_post_len", {54'd0, olen}, 64'd66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
